output_port_bank: RTL and testbench
===================================

// Module: output_port_bank
// PURPOSE
//  Parametrised CPU output-port bank: OUT instruction copies one of NREG source registers to any subset of NCH channels.
//  Each channel is LATCHED (holds last value) or STROBE (per-channel FIFO drained by a valid/ready consumer).
//  Writes arriving during an interrupt are deferred (DEFER=1) or dropped (DEFER=0). Sits between register file and peripherals.
// PARAMETERS
//  DATA_W      16       channel / register data width
//  NREG        4        number of selectable source registers (>=2)
//  NCH         2        number of output channels (1..8)
//  LATCH_MASK  'b01     bit c=1: channel c LATCHED; bit c=0: channel c STROBE
//  FIFO_DEPTH  4        entries per STROBE channel FIFO (power of 2, >=2)
//  DEFER       1        1: hold interrupted write in pending slot; 0: drop it
// PORTS
//  clk        in   1                 clock, all logic on rising edge
//  rst        in   1                 synchronous, active-high reset
//  s          in   1                 OUT instruction execute strobe
//  inter      in   1                 interrupt in progress
//  reg_sel    in   $clog2(NREG)      source register index
//  sreg_flat  in   NREG*DATA_W       source registers, reg r at [r*DATA_W +: DATA_W]
//  out_en     in   NCH               target channel mask
//  out_data   out  NCH*DATA_W        channel c data at [c*DATA_W +: DATA_W]
//  out_valid  out  NCH               LATCHED: 1-cycle update pulse; STROBE: FIFO non-empty
//  out_ready  in   NCH               STROBE consumer accept; ignored for LATCHED
//  fifo_full  out  NCH               STROBE FIFO full (0 for LATCHED)
//  ovf        out  NCH               sticky: STROBE write dropped because full
//  ovf_clr    in   NCH               clear ovf bits (set wins over clear same cycle)
//  pend       out  1                 deferred write waiting
// BEHAVIOUR
//  - Reset (sync): out_data=0, out_valid=0, fifos empty, fifo_full=0, ovf=0, pend=0, pending slot cleared.
//  - Request = s & |out_en. Data = sreg_flat slice at reg_sel, sampled in the request cycle; reg_sel>=NREG -> data 0.
//  - inter=0, no pending: commit in request cycle; effect visible next cycle (latency 1).
//  - inter=1, DEFER=1: {data,out_en} stored in pending slot, pend=1; a later request while pending overwrites it (latest wins).
//  - inter=1, DEFER=0: request discarded, no state change.
//  - Pending commits in first cycle with inter=0; a new request in that same cycle is captured into pending (commits next cycle), preserving order.
//  - Commit to LATCHED c (en bit set): out_data[c]<=data, out_valid[c]=1 next cycle only; otherwise out_data holds, valid=0.
//  - Commit to STROBE c: push data. out_data[c]=FIFO head, 0 when empty; out_valid[c]=!empty; pop on valid&ready.
//  - Push when full: accepted only if same-cycle pop; else dropped and ovf[c] set. Push+pop when empty: push only.
//  - FIFO pointers wrap mod FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1; full = count==FIFO_DEPTH.
//  - Reset mid-operation: pending and FIFO contents discarded, no partial commit.
// STRUCTURE
//  - Package q16_out_pkg: DATA_W default, channel mode constants (MODE_LATCH/MODE_STROBE), slice helper function.
//  - Sub-module out_fifo (DATA_W, FIFO_DEPTH): sync FIFO with push/pop/full/empty/head; generate one per STROBE channel.
//  - Top: request/pending logic, source mux, generate loop per channel selecting latch reg or out_fifo.
// TESTING
//  1 NCH=2 defaults; sreg1=16'hBEEF, s=1,reg_sel=1,out_en=01,inter=0 -> next cycle ch0=BEEF, out_valid[0] 1 cycle, then holds.
//  2 ch1 STROBE, ready=0: 5 writes 1..5 -> fifo_full after 4th, ovf[1]=1 after 5th, head=1; ready=1 -> 1,2,3,4 then valid=0,data=0.
//  3 inter=1 write 0x1234 then 0x5678 to ch0 -> pend=1, ch0 unchanged; inter=0 -> ch0=0x5678 next cycle, pend=0.
//  4 DEFER=0, inter=1 write 0xAAAA -> no change on any output, pend stays 0.
//  5 FIFO full + push with ready=1 same cycle -> push accepted, ovf stays 0, count stays 4; ovf_clr with new overflow -> ovf stays 1.
//  6 rst asserted with pend=1 and FIFO count 3 -> next cycle all outputs 0, pend=0, FIFO empty.

Source files
------------

// File: rtl/q16_out_pkg.sv
// q16_out_pkg: shared defaults, channel mode constants and mode lookup helper for the output port bank
package q16_out_pkg;
  localparam int DATA_W_DEF = 16;
  localparam logic MODE_LATCH = 1'b1;
  localparam logic MODE_STROBE = 1'b0;
  function automatic logic ch_mode(input logic [7:0] mask, input logic [2:0] c);
    return mask[c];
  endfunction
endpackage

// File: rtl/out_fifo.sv
// out_fifo: sync FIFO for one STROBE channel
// Ports: clk/rst; push/pop requests; head (0 when empty); empty; full; drop (push refused because full without pop)
module out_fifo #(
  parameter int DATA_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              drop
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign do_pop = pop & !empty;
  // a full FIFO still takes a push when the same cycle frees a slot
  assign do_push = push & (!full | do_pop);
  assign drop = push & !do_push;
  assign head = empty ? '0 : mem[rd];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/output_port_bank.sv
// output_port_bank: OUT instruction copies a source register to a subset of LATCHED/STROBE output channels
// Ports: s/inter/reg_sel/sreg_flat/out_en form the OUT request; out_data/out_valid/out_ready per channel;
// fifo_full, sticky ovf (cleared by ovf_clr) per STROBE channel; pend flags a deferred write
module output_port_bank
  import q16_out_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG = 4,
  parameter int NCH = 2,
  parameter logic [7:0] LATCH_MASK = 8'b01,
  parameter int FIFO_DEPTH = 4,
  parameter logic DEFER = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s,
  input  logic                    inter,
  input  logic [$clog2(NREG)-1:0] reg_sel,
  input  logic [NREG*DATA_W-1:0]  sreg_flat,
  input  logic [NCH-1:0]          out_en,
  output logic [NCH*DATA_W-1:0]   out_data,
  output logic [NCH-1:0]          out_valid,
  input  logic [NCH-1:0]          out_ready,
  output logic [NCH-1:0]          fifo_full,
  output logic [NCH-1:0]          ovf,
  input  logic [NCH-1:0]          ovf_clr,
  output logic                    pend
);
  localparam int RSW = $clog2(NREG);
  logic req, store, commit;
  logic [DATA_W-1:0] data, pend_data, cdata;
  logic [NCH-1:0] pend_en, cen;
  assign req = s & |out_en;
  always_comb begin
    data = '0;
    for (int r = 0; r < NREG; r++)
      if (reg_sel == RSW'(r)) data = sreg_flat[r*DATA_W +: DATA_W];
  end
  // a pending write always commits before a newer request, which then takes the slot
  assign store = req & (inter ? DEFER : pend);
  assign commit = !inter & (pend | req);
  assign cdata = pend ? pend_data : data;
  assign cen = pend ? pend_en : out_en;
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      pend_data <= '0;
      pend_en <= '0;
    end else begin
      pend <= store | (inter & pend);
      if (store) begin
        pend_data <= data;
        pend_en <= out_en;
      end
    end
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    if (ch_mode(LATCH_MASK, 3'(c)) == MODE_LATCH) begin : g_lat
      logic [DATA_W-1:0] d_q;
      logic v_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          d_q <= '0;
          v_q <= 1'b0;
        end else begin
          v_q <= commit & cen[c];
          if (commit & cen[c]) d_q <= cdata;
        end
      end
      assign out_data[c*DATA_W +: DATA_W] = d_q;
      assign out_valid[c] = v_q;
      assign fifo_full[c] = 1'b0;
      assign ovf[c] = 1'b0;
    end else begin : g_stb
      logic empty, drop, o_q;
      out_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(commit & cen[c]),
        .pop(out_ready[c]),
        .din(cdata),
        .head(out_data[c*DATA_W +: DATA_W]),
        .empty(empty),
        .full(fifo_full[c]),
        .drop(drop)
      );
      // set wins over a same-cycle clear
      always_ff @(posedge clk) begin
        if (rst) o_q <= 1'b0;
        else o_q <= drop | (o_q & ~ovf_clr[c]);
      end
      assign out_valid[c] = !empty;
      assign ovf[c] = o_q;
    end
  end
endmodule

// File: tb/tb_output_port_bank.sv
// tb_output_port_bank: scoreboard bench for output_port_bank (DEFER=1 main instance, DEFER=0 shadow instance)
module tb_output_port_bank;
  logic clk = 1'b0;
  logic rst, s, inter;
  logic [1:0] reg_sel;
  logic [63:0] sreg_flat;
  logic [1:0] out_en, out_ready, ovf_clr;
  logic [31:0] out_data, out_data_b;
  logic [1:0] out_valid, fifo_full, ovf, out_valid_b, fifo_full_b, ovf_b;
  logic pend, pend_b;
  int passed = 0;
  int total = 0;
  logic [15:0] q[$];
  always #5 clk = ~clk;
  output_port_bank dut (
    .clk(clk), .rst(rst), .s(s), .inter(inter), .reg_sel(reg_sel), .sreg_flat(sreg_flat),
    .out_en(out_en), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_full(fifo_full), .ovf(ovf), .ovf_clr(ovf_clr), .pend(pend)
  );
  output_port_bank #(.DEFER(1'b0)) dut_b (
    .clk(clk), .rst(rst), .s(s), .inter(inter), .reg_sel(reg_sel), .sreg_flat(sreg_flat),
    .out_en(out_en), .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .fifo_full(fifo_full_b), .ovf(ovf_b), .ovf_clr(ovf_clr), .pend(pend_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] v, input logic [1:0] en);
    sreg_flat[15:0] = v;
    reg_sel = 2'd0;
    out_en = en;
    s = 1'b1;
    tick();
    s = 1'b0;
    out_en = 2'b00;
  endtask
  task automatic drain(input string tag);
    out_ready[1] = 1'b1;
    for (int n = 0; n < 12 && q.size() > 0; n++) begin
      if (out_valid[1]) chk(tag, {16'h0, out_data[31:16]}, {16'h0, q.pop_front()});
      tick();
    end
    out_ready[1] = 1'b0;
    chk({tag, "_left"}, q.size(), 0);
    chk({tag, "_valid"}, {31'h0, out_valid[1]}, 0);
    chk({tag, "_data"}, {16'h0, out_data[31:16]}, 0);
  endtask
  initial begin
    rst = 1'b1; s = 1'b0; inter = 1'b0; reg_sel = 2'd0; sreg_flat = '0;
    out_en = 2'b00; out_ready = 2'b00; ovf_clr = 2'b00;
    tick(); tick();
    rst = 1'b0;
    chk("rst_data", out_data, 0);
    chk("rst_valid", {30'h0, out_valid}, 0);
    chk("rst_misc", {27'h0, fifo_full, ovf, pend}, 0);
    // latched channel 0, register 1
    sreg_flat[31:16] = 16'hBEEF;
    reg_sel = 2'd1; out_en = 2'b01; s = 1'b1;
    tick();
    s = 1'b0; out_en = 2'b00;
    chk("t1_data", {16'h0, out_data[15:0]}, 32'hBEEF);
    chk("t1_valid", {30'h0, out_valid}, 32'h1);
    tick();
    chk("t1_hold", {16'h0, out_data[15:0]}, 32'hBEEF);
    chk("t1_pulse", {31'h0, out_valid[0]}, 0);
    // strobe channel 1 overflow
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q.push_back(16'(i));
      wr(16'(i), 2'b10);
      if (i == 4) chk("t2_full", {30'h0, fifo_full}, 32'h2);
      if (i == 4) chk("t2_noovf", {30'h0, ovf}, 0);
    end
    chk("t2_ovf", {30'h0, ovf}, 32'h2);
    chk("t2_head", {16'h0, out_data[31:16]}, 32'h1);
    chk("t2_ch0", {16'h0, out_data[15:0]}, 32'hBEEF);
    drain("t2_drain");
    ovf_clr = 2'b10;
    tick();
    ovf_clr = 2'b00;
    chk("t2_clr", {30'h0, ovf}, 0);
    // deferred writes, latest wins; DEFER=0 instance must ignore them
    inter = 1'b1;
    wr(16'h1234, 2'b01);
    wr(16'h5678, 2'b01);
    sreg_flat[15:0] = 16'h0;
    chk("t3_pend", {31'h0, pend}, 1);
    chk("t3_ch0", {16'h0, out_data[15:0]}, 32'hBEEF);
    chk("t4_pend", {31'h0, pend_b}, 0);
    chk("t4_ch0", {16'h0, out_data_b[15:0]}, 32'hBEEF);
    chk("t4_valid", {30'h0, out_valid_b}, 0);
    inter = 1'b0;
    tick();
    chk("t3_commit", {16'h0, out_data[15:0]}, 32'h5678);
    chk("t3_cvalid", {31'h0, out_valid[0]}, 1);
    chk("t3_unpend", {31'h0, pend}, 0);
    chk("t4_after", {16'h0, out_data_b[15:0]}, 32'hBEEF);
    // pending commit and new request in the same cycle keep order
    inter = 1'b1;
    wr(16'h1111, 2'b01);
    inter = 1'b0;
    wr(16'h2222, 2'b01);
    chk("ord_first", {16'h0, out_data[15:0]}, 32'h1111);
    chk("ord_pend", {31'h0, pend}, 1);
    tick();
    chk("ord_second", {16'h0, out_data[15:0]}, 32'h2222);
    chk("ord_unpend", {31'h0, pend}, 0);
    // full FIFO push with same-cycle pop, then overflow racing a clear
    for (int i = 1; i <= 4; i++) begin
      q.push_back(16'hA000 + 16'(i));
      wr(16'hA000 + 16'(i), 2'b10);
    end
    chk("t5_full", {31'h0, fifo_full[1]}, 1);
    out_ready[1] = 1'b1;
    chk("t5_head", {16'h0, out_data[31:16]}, {16'h0, q.pop_front()});
    q.push_back(16'hA005);
    wr(16'hA005, 2'b10);
    out_ready[1] = 1'b0;
    chk("t5_noovf", {31'h0, ovf[1]}, 0);
    chk("t5_still_full", {31'h0, fifo_full[1]}, 1);
    ovf_clr = 2'b10;
    wr(16'hA006, 2'b10);
    ovf_clr = 2'b00;
    chk("t5_setwins", {31'h0, ovf[1]}, 1);
    drain("t5_drain");
    // reset mid-operation
    ovf_clr = 2'b10;
    tick();
    ovf_clr = 2'b00;
    for (int i = 1; i <= 3; i++) wr(16'hC000 + 16'(i), 2'b10);
    inter = 1'b1;
    wr(16'h7777, 2'b01);
    chk("t6_pre_pend", {31'h0, pend}, 1);
    chk("t6_pre_valid", {31'h0, out_valid[1]}, 1);
    rst = 1'b1;
    tick();
    chk("t6_data", out_data, 0);
    chk("t6_flags", {25'h0, out_valid, fifo_full, ovf, pend}, 0);
    rst = 1'b0;
    inter = 1'b0;
    tick();
    chk("t6_nocommit", out_data, 0);
    chk("t6_empty", {29'h0, out_valid, pend}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
